// File: rtl/reqack_pkg.sv
// Shared types and constants for the round-robin req/ack sequencer.
package reqack_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE,
    ST_INTR,
    ST_TOUT
  } reqack_state_e;

  localparam int REQACK_MAX_ACK_DEFAULT = 5;
  localparam int REQACK_INTR_WIN        = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         rq_i,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt_next,
  output logic [$clog2(N)-1:0] idx_next
);

  localparam int IDX_W = $clog2(N);

  logic             found;
  logic [IDX_W-1:0] jj;

  // Walk the requesters starting at ptr and keep only the first hit.
  always_comb begin
    gnt_next = '0;
    idx_next = '0;
    found    = 1'b0;
    jj       = '0;
    for (int i = 0; i < N; i++) begin
      jj = IDX_W'((int'(ptr) + i) % N);
      if (!found && rq_i[jj]) begin
        found        = 1'b1;
        gnt_next[jj] = 1'b1;
        idx_next     = jj;
      end
    end
  end

endmodule

// File: rtl/reqack_sequencer.sv
// Shares one req/ack/done target among N requesters in round-robin order,
// with an ack timeout. All outputs are decoded from registered state.
module reqack_sequencer
  import reqack_pkg::*;
#(
  parameter int N       = 4,
  parameter int MAX_ACK = REQACK_MAX_ACK_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] rq_i,
  output logic [N-1:0] gnt_o,
  output logic [N-1:0] done_o,
  output logic         req,
  input  logic         ack,
  output logic         done,
  output logic         intrpt,
  output logic         timeout_err,
  output logic         busy
);

  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(MAX_ACK + 1);

  reqack_state_e    state_q;
  reqack_state_e    state_d;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] win_idx;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0]     gnt_next;
  logic [IDX_W-1:0] idx_next;

  rr_arbiter #(
    .N(N)
  ) u_arb (
    .rq_i    (rq_i),
    .ptr     (ptr),
    .gnt_next(gnt_next),
    .idx_next(idx_next)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; ack only matters in WAIT, requests only in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (|rq_i) state_d = ST_REQ;
      ST_REQ:  state_d = ST_WAIT;
      ST_WAIT: begin
        if (ack) begin
          state_d = ST_DONE;
        end else if (cnt == CNT_W'(MAX_ACK)) begin
          state_d = ST_TOUT;
        end
      end
      ST_DONE: state_d = ST_INTR;
      ST_INTR: state_d = ST_IDLE;
      ST_TOUT: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Cycles since req: zero during REQ, so it reads k in the k-th WAIT cycle; saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (state_q == ST_REQ || state_q == ST_WAIT) begin
      if (cnt != CNT_W'(MAX_ACK)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

  // Grant latch and round-robin pointer; pointer moves past the winner when the transfer ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_o   <= '0;
      win_idx <= '0;
      ptr     <= '0;
    end else begin
      if (state_q == ST_IDLE && (|rq_i)) begin
        gnt_o   <= gnt_next;
        win_idx <= idx_next;
      end else if (state_q == ST_INTR || state_q == ST_TOUT) begin
        gnt_o <= '0;
        ptr   <= (win_idx == IDX_W'(N - 1)) ? '0 : win_idx + IDX_W'(1);
      end
    end
  end

  assign req         = (state_q == ST_REQ);
  assign done        = (state_q == ST_DONE);
  assign intrpt      = (state_q == ST_INTR);
  assign timeout_err = (state_q == ST_TOUT);
  assign busy        = (state_q != ST_IDLE);
  assign done_o      = done ? gnt_o : '0;

endmodule
